// File: rtl/motor_control_pkg.sv
// Shared types and switch-bit indices for the dual H-bridge motor controller.
package motor_control_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2,
        DEAD = 2'd3
    } chan_state_t;

    localparam int SW_A_EN  = 0;
    localparam int SW_A_REV = 1;
    localparam int SW_B_EN  = 2;
    localparam int SW_B_REV = 3;

endpackage

// File: rtl/motor_control_if.sv
// Switch inputs and H-bridge pin outputs of one motor controller instance.
// Board side drives sw (master); the controller drives the bridge pins (slave).
interface motor_control_if;
    logic [3:0] sw;
    logic       hbridge1a;
    logic       hbridge2a;
    logic       hbridge1b;
    logic       hbridge2b;

    modport master (output sw, input hbridge1a, hbridge2a, hbridge1b, hbridge2b);
    modport slave  (input sw, output hbridge1a, hbridge2a, hbridge1b, hbridge2b);
endinterface

// File: rtl/hbridge_channel.sv
// One bridge channel: OFF/FWD/REV/DEAD FSM with dead-time on reversals, registered legs.
// Latency: one cycle from en/rev to legs; no backpressure (free-running).
module hbridge_channel
    import motor_control_pkg::*;
#(
    parameter int DEAD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic rev,
    input  logic pwm,
    output logic in1,
    output logic in2
);
    localparam int DC = (DEAD_CYCLES < 1) ? 1 : DEAD_CYCLES;
    localparam int DW = $clog2(DC + 1);

    chan_state_t   state;
    chan_state_t   nxt;
    logic [DW-1:0] dcnt;

    always_comb begin
        nxt = state;
        case (state)
            OFF:  if (en) nxt = rev ? REV : FWD;
            FWD:  if (!en) nxt = OFF; else if (rev) nxt = DEAD;
            REV:  if (!en) nxt = OFF; else if (!rev) nxt = DEAD;
            // Legs are already low here; the count runs to completion regardless of commands.
            DEAD: if (dcnt == '0) nxt = !en ? OFF : (rev ? REV : FWD);
            default: nxt = OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OFF;
            dcnt  <= '0;
            in1   <= 1'b0;
            in2   <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt == DEAD && state != DEAD)
                dcnt <= DW'(DC - 1);
            else if (dcnt != '0)
                dcnt <= dcnt - 1'b1;
            // Decoding from nxt keeps in1/in2 mutually exclusive by construction.
            in1 <= (nxt == FWD) && pwm;
            in2 <= (nxt == REV) && pwm;
        end
    end
endmodule

// File: rtl/motor_control.sv
// Dual H-bridge driver: switch synchronizer, shared PWM counter, two channel FSMs.
// Latency: sw change before edge N appears on the bridge pins after edge N+2; no backpressure.
module motor_control
    import motor_control_pkg::*;
#(
    parameter int PWM_PERIOD  = 100,
    parameter int DUTY        = 75,
    parameter int DEAD_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    motor_control_if.slave  bus
);
    localparam int CW = (PWM_PERIOD > 2) ? $clog2(PWM_PERIOD) : 1;

    logic [3:0]    sw_s1;
    logic [3:0]    sw_s2;
    logic [CW-1:0] cnt;
    logic          pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            cnt   <= '0;
        end else begin
            sw_s1 <= bus.sw;
            sw_s2 <= sw_s1;
            cnt   <= (cnt == CW'(PWM_PERIOD - 1)) ? '0 : cnt + 1'b1;
        end
    end

    // DUTY >= PWM_PERIOD never compares false, giving a constant-high drive.
    assign pwm = (int'(cnt) < DUTY);

    hbridge_channel #(.DEAD_CYCLES(DEAD_CYCLES)) u_chan_a (
        .clk (clk),
        .rst (rst),
        .en  (sw_s2[SW_A_EN]),
        .rev (sw_s2[SW_A_REV]),
        .pwm (pwm),
        .in1 (bus.hbridge1a),
        .in2 (bus.hbridge2a)
    );

    hbridge_channel #(.DEAD_CYCLES(DEAD_CYCLES)) u_chan_b (
        .clk (clk),
        .rst (rst),
        .en  (sw_s2[SW_B_EN]),
        .rev (sw_s2[SW_B_REV]),
        .pwm (pwm),
        .in1 (bus.hbridge1b),
        .in2 (bus.hbridge2b)
    );
endmodule

// File: tb/tb_motor_control.sv
// Directed and randomized checks of motor_control with PWM_PERIOD=4, DEAD_CYCLES=4.
// Three instances share clk/rst/sw: DUTY=4 (main), DUTY=2 and DUTY=0 (PWM shape).
module tb_motor_control;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    motor_control_if bus ();
    motor_control_if bus2 ();
    motor_control_if bus0 ();
    assign bus.sw  = sw;
    assign bus2.sw = sw;
    assign bus0.sw = sw;

    motor_control #(.PWM_PERIOD(4), .DUTY(4), .DEAD_CYCLES(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    motor_control #(.PWM_PERIOD(4), .DUTY(2), .DEAD_CYCLES(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    motor_control #(.PWM_PERIOD(4), .DUTY(0), .DEAD_CYCLES(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    // {1a, 2a, 1b, 2b} of the main instance
    function automatic logic [3:0] outs();
        return {bus.hbridge1a, bus.hbridge2a, bus.hbridge1b, bus.hbridge2b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] v);
        rst = 1'b1;
        sw  = v;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw  = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (outs() !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b want 0000", i, outs());
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (outs() !== 4'b0000) begin
                errors++;
                $display("FAIL reset_sync[%0d]: got %b want 0000", i, outs());
            end
        end
        tick();
        checks++;
        if (outs() !== 4'b0101) begin
            errors++;
            $display("FAIL reset_rev_start: got %b want 0101", outs());
        end
    endtask

    task automatic test_fwd_start();
        do_reset(4'b0000);
        sw = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (outs() !== 4'b0000) begin
                errors++;
                $display("FAIL fwd_latency[%0d]: got %b want 0000", i, outs());
            end
        end
        tick();
        checks++;
        if (outs() !== 4'b1000) begin
            errors++;
            $display("FAIL fwd_on: got %b want 1000", outs());
        end
    endtask

    task automatic test_reversal();
        sw = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (outs() !== 4'b1000) begin
                errors++;
                $display("FAIL rev_latency[%0d]: got %b want 1000", i, outs());
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (outs() !== 4'b0000) begin
                errors++;
                $display("FAIL rev_dead[%0d]: got %b want 0000", i, outs());
            end
        end
        tick();
        checks++;
        if (outs() !== 4'b0100) begin
            errors++;
            $display("FAIL rev_on: got %b want 0100", outs());
        end
        sw = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (outs() !== 4'b0100) begin
                errors++;
                $display("FAIL coast_latency[%0d]: got %b want 0100", i, outs());
            end
        end
        tick();
        checks++;
        if (outs() !== 4'b0000) begin
            errors++;
            $display("FAIL coast_off: got %b want 0000", outs());
        end
    endtask

    task automatic test_channel_b();
        do_reset(4'b0000);
        sw = 4'b0100;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (outs() !== 4'b0010) begin
            errors++;
            $display("FAIL b_fwd: got %b want 0010", outs());
        end
        sw = 4'b1100;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (outs() !== 4'b0010) begin
                errors++;
                $display("FAIL b_rev_latency[%0d]: got %b want 0010", i, outs());
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (outs() !== 4'b0000) begin
                errors++;
                $display("FAIL b_dead[%0d]: got %b want 0000", i, outs());
            end
        end
        tick();
        checks++;
        if (outs() !== 4'b0001) begin
            errors++;
            $display("FAIL b_rev_on: got %b want 0001", outs());
        end
    endtask

    // Counter is 0 across the reset edges, so edge k after release sees cnt=(k-1)%4.
    task automatic test_duty();
        logic e2;
        logic emain;
        do_reset(4'b0001);
        for (int k = 1; k <= 10; k++) begin
            tick();
            e2    = (k >= 3) && (((k - 1) % 4) < 2);
            emain = (k >= 3);
            checks++;
            if (bus2.hbridge1a !== e2) begin
                errors++;
                $display("FAIL duty2_1a[k=%0d]: got %b want %b", k, bus2.hbridge1a, e2);
            end
            checks++;
            if (bus0.hbridge1a !== 1'b0) begin
                errors++;
                $display("FAIL duty0_1a[k=%0d]: got %b want 0", k, bus0.hbridge1a);
            end
            checks++;
            if (bus.hbridge1a !== emain) begin
                errors++;
                $display("FAIL duty4_1a[k=%0d]: got %b want %b", k, bus.hbridge1a, emain);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] d1 = 4'b0000;
        logic [3:0] d2 = 4'b0000;
        int         hold = 1;
        int         low_run [2] = '{0, 0};
        int         last_leg [2] = '{0, 0};
        bit         coasted [2] = '{0, 0};
        logic       l1, l2, en;
        int         leg;
        do_reset(4'b0000);
        for (int cyc = 0; cyc < 10000; cyc++) begin
            tick();
            d2 = d1;
            d1 = sw;
            for (int c = 0; c < 2; c++) begin
                l1 = (c == 0) ? bus.hbridge1a : bus.hbridge1b;
                l2 = (c == 0) ? bus.hbridge2a : bus.hbridge2b;
                en = (c == 0) ? d2[0] : d2[2];
                checks++;
                if ((l1 & l2) !== 1'b0) begin
                    errors++;
                    $display("FAIL overlap[ch%0d cyc=%0d]: got in1=%b in2=%b want not both 1", c, cyc, l1, l2);
                end
                leg = l1 ? 1 : (l2 ? 2 : 0);
                if (leg != 0) begin
                    // A reversal is excused from dead-time only if the channel was disabled in between.
                    if (last_leg[c] != 0 && leg != last_leg[c] && !coasted[c]) begin
                        checks++;
                        if (low_run[c] < 4) begin
                            errors++;
                            $display("FAIL deadtime[ch%0d cyc=%0d]: got %0d low cycles want >=4", c, cyc, low_run[c]);
                        end
                    end
                    last_leg[c] = leg;
                    low_run[c]  = 0;
                    coasted[c]  = 1'b0;
                end else begin
                    low_run[c]++;
                end
                if (!en) coasted[c] = 1'b1;
            end
            hold--;
            if (hold == 0) begin
                sw   = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 7);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        sw  = 4'b0000;
        test_reset();
        test_fwd_start();
        test_reversal();
        test_channel_b();
        test_duty();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
